// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock FIFO with selectable read style and sticky error flags.
//
// Read styles:
//   FWFT = 0 : registered read. o_data is loaded with the head word on the
//              edge that accepts a read and holds its value otherwise.
//   FWFT = 1 : first-word-fall-through. o_data shows the head word whenever
//              the FIFO is non-empty; rden pops it.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst_n        - synchronous active-low reset
//   wren, i_data - write request and write data
//   rden         - read request
//   clr_err      - clears the sticky overflow/underflow flags
//   o_data       - read data
//   full, empty  - occupancy flags (registered)
//   almost_full  - count >= AF_LEVEL (registered)
//   almost_empty - count <= AE_LEVEL (registered)
//   count        - current occupancy, 0..DEPTH
//   overflow     - sticky: write attempted while full
//   underflow    - sticky: read attempted while empty

module sync_fifo_fwft #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wren,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       rden,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance looks only at the flags as they stand before the edge, so a
    // write into a full FIFO is dropped even if a read frees a slot this cycle.
    assign wr_ok = wren && !full;
    assign rd_ok = rden && !empty;

    // Next occupancy; a simultaneous accepted read and write cancel out.
    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, occupancy and all status flags. Flags are computed from the
    // next count so they land in the same cycle as the new count value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count        <= count_next;
            full         <= (count_next == CW'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CW'(AF_LEVEL));
            almost_empty <= (count_next <= CW'(AE_LEVEL));
        end
    end

    // Sticky error flags. A new error in the same cycle as clr_err wins so
    // that no error event can be lost to a concurrent clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rden && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage array. It is deliberately not reset; reset-cycle writes are
    // suppressed so a reset never lands a stray word.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word falls through combinationally; forced to zero while
            // empty so the output is clean out of reset.
            assign o_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_q;

            // Output register loads the head word only on an accepted read.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (rd_ok) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign o_data = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft
// Directed self-checking bench. Two FIFOs share every input: dut0 uses the
// registered read style, dut1 the fall-through style, so both read paths are
// checked against the same stimulus.

module tb_sync_fifo_fwft;

    logic       clk;
    logic       rst_n;
    logic       wren;
    logic [7:0] i_data;
    logic       rden;
    logic       clr_err;

    logic [7:0] o_data0, o_data1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] count0, count1;

    int errors = 0;
    int checks = 0;

    sync_fifo_fwft #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
        .clr_err(clr_err), .o_data(o_data0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_fwft #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
        .clr_err(clr_err), .o_data(o_data1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, then step to 1 time unit past the edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d,
                                 input logic r, input logic c);
        wren    = w;
        i_data  = d;
        rden    = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("rst_count", 32'(count0), 32'd0);
        checkOutput("rst_empty", 32'(empty0), 32'd1);
        checkOutput("rst_ae", 32'(ae0), 32'd1);
        checkOutput("rst_full", 32'(full0), 32'd0);
        checkOutput("rst_af", 32'(af0), 32'd0);
        checkOutput("rst_ovf", 32'(ovf0), 32'd0);
        checkOutput("rst_unf", 32'(unf0), 32'd0);
        checkOutput("rst_odata0", 32'(o_data0), 32'd0);
        checkOutput("rst_empty1", 32'(empty1), 32'd1);
        rst_n = 1'b1;

        // Fill with 0x11..0x18; almost_full from count 6, full at 8.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            checkOutput("fill_count", 32'(count0), 32'(i + 1));
            checkOutput("fill_af", 32'(af0), 32'((i + 1) >= 6));
            checkOutput("fill_full", 32'(full0), 32'((i + 1) == 8));
            checkOutput("fill_ae", 32'(ae0), 32'((i + 1) <= 2));
            checkOutput("fill_fwft_head", 32'(o_data1), 32'h11);
        end
        checkOutput("fill_empty1", 32'(empty1), 32'd0);

        // Write while full is dropped and raises overflow.
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(ovf0), 32'd1);
        checkOutput("ovf_set1", 32'(ovf1), 32'd1);
        checkOutput("ovf_count", 32'(count0), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_sticky", 32'(ovf0), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_clear", 32'(ovf0), 32'd0);

        // Drain; registered output shows each word after its read edge,
        // fall-through output already shows the next one.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_data0", 32'(o_data0), 32'(8'h11 + i));
            checkOutput("drain_count", 32'(count0), 32'(7 - i));
            checkOutput("drain_ae", 32'(ae0), 32'((7 - i) <= 2));
            if (i < 7) begin
                checkOutput("drain_data1", 32'(o_data1), 32'(8'h12 + i));
            end
        end
        checkOutput("drain_empty", 32'(empty0), 32'd1);

        // Read while empty raises underflow, output holds last word.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("unf_set", 32'(unf0), 32'd1);
        checkOutput("unf_hold", 32'(o_data0), 32'h18);
        checkOutput("unf_count", 32'(count0), 32'd0);
        // New underflow alongside clr_err keeps the flag set.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("unf_setwins", 32'(unf0), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("unf_clear", 32'(unf0), 32'd0);

        // Single word into empty: fall-through shows it next cycle.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("fwft_empty", 32'(empty1), 32'd0);
        checkOutput("fwft_data", 32'(o_data1), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fwft_pop_empty", 32'(empty1), 32'd1);
        checkOutput("fwft_pop_data0", 32'(o_data0), 32'hA5);

        // Full plus simultaneous read/write: read taken, write dropped.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        end
        checkOutput("rw_full", 32'(full0), 32'd1);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("rw_full_data", 32'(o_data0), 32'h21);
        checkOutput("rw_full_ovf", 32'(ovf0), 32'd1);
        checkOutput("rw_full_count", 32'(count0), 32'd7);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("rw_mid_count", 32'(count0), 32'd4);
        checkOutput("rw_mid_data", 32'(o_data0), 32'h24);
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        checkOutput("rw_mid_count2", 32'(count0), 32'd4);
        checkOutput("rw_mid_data2", 32'(o_data0), 32'h25);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rw_order0", 32'(o_data0), 32'h26);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rw_order1", 32'(o_data0), 32'h27);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rw_order2", 32'(o_data0), 32'h28);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rw_order3", 32'(o_data0), 32'h30);
        checkOutput("rw_order_empty", 32'(empty0), 32'd1);

        // Twenty interleaved words stream through, crossing pointer wrap.
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
            checkOutput("wrap_data0", 32'(o_data0), 32'(8'h40 + k - 1));
            checkOutput("wrap_data1", 32'(o_data1), 32'(8'h40 + k));
            checkOutput("wrap_count", 32'(count0), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("wrap_last", 32'(o_data0), 32'h53);
        checkOutput("wrap_empty", 32'(empty0), 32'd1);
        checkOutput("wrap_ovf", 32'(ovf0), 32'd0);
        checkOutput("wrap_unf", 32'(unf0), 32'd0);
        checkOutput("wrap_full", 32'(full0), 32'd0);

        // Reset mid-operation at count 5 with overflow pending.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("pre_rst_count", 32'(count0), 32'd5);
        checkOutput("pre_rst_ovf", 32'(ovf0), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
        rst_n = 1'b1;
        checkOutput("mid_rst_count", 32'(count0), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty0), 32'd1);
        checkOutput("mid_rst_ovf", 32'(ovf0), 32'd0);
        checkOutput("mid_rst_data0", 32'(o_data0), 32'd0);
        checkOutput("mid_rst_data1", 32'(o_data1), 32'd0);
        checkOutput("mid_rst_count1", 32'(count1), 32'd0);

        // FIFO works normally after the reset.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("post_rst_data1", 32'(o_data1), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_data0", 32'(o_data0), 32'h5A);
        checkOutput("post_rst_empty", 32'(empty0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
